i2c_reg_sequencer: RTL

Wishbone-master command sequencer that drives the `i2c_master_top` byte controller through its 8-bit register map to perform complete single-byte I2C register transactions. It issues START, device address, register address, data, repeated START and STOP. It sits beside the AXI-Lite-to-Wishbone path and converts one command-channel request into the full series of PRER/CTR/TXR/CR writes and SR/RXR reads. It reports read data and a completion status.

---
 rtl/i2c_reg_sequencer_pkg.sv | 11 +
 rtl/i2c_reg_sequencer_if.sv | 24 ++
 rtl/i2c_reg_sequencer_wb_access.sv | 47 ++++
 rtl/i2c_reg_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_sequencer_pkg.sv
// i2c_seq_pkg: register map, CR command bytes, SR bit positions, error codes and top FSM states
package i2c_seq_pkg;
  localparam logic [2:0] PRERLO = 3'd0, PRERHI = 3'd1, CTR = 3'd2, TXR_RXR = 3'd3, CR_SR = 3'd4;
  localparam logic [7:0] CMD_STA_WR = 8'h90, CMD_WR = 8'h10, CMD_STO_WR = 8'h50;
  localparam logic [7:0] CMD_RD_NACK_STO = 8'h68, CMD_STO = 8'h40, CTR_EN = 8'h80;
  localparam int SR_RXACK = 7, SR_BUSY = 6, SR_AL = 5, SR_TIP = 1;
  typedef enum logic [1:0] {ERR_OK, ERR_ADDR_NACK, ERR_DATA_NACK, ERR_AL_TMO} err_e;
  typedef logic [3:0] state_t;
  localparam state_t INIT = 4'd0, IDLE = 4'd1, TX_WR = 4'd2, CR_WR = 4'd3, POLL = 4'd4;
  localparam state_t RX_RD = 4'd5, ABORT_STO = 4'd6, ABORT_POLL = 4'd7, RESP = 4'd8;
endpackage

// File: rtl/i2c_reg_sequencer_if.sv
// i2c_reg_sequencer_if: command/response channel plus Wishbone master bus; master = sequencer, slave = environment
interface i2c_reg_sequencer_if;
  import i2c_seq_pkg::*;
  logic cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_wdata;
  logic rsp_valid;
  logic [7:0] rsp_rdata;
  err_e rsp_err;
  logic init_done;
  logic wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o, wb_dat_i;
  modport master(
    input cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata, wb_dat_i, wb_ack_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, init_done,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );
  modport slave(
    output cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata, wb_dat_i, wb_ack_i,
    input cmd_ready, rsp_valid, rsp_rdata, rsp_err, init_done,
    input wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );
endinterface

// File: rtl/i2c_reg_sequencer_wb_access.sv
// i2c_wb_access: one Wishbone classic access per go (go/we/adr/wdata in, done/rdata out, wb_* master pins)
module i2c_wb_access (
  input  logic       clk,
  input  logic       rst,
  input  logic       go_i,
  input  logic       we_i,
  input  logic [2:0] adr_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);
  localparam logic [1:0] W_IDLE = 2'd0, W_REQ = 2'd1, W_DONE = 2'd2;
  logic [1:0] st_q, st_d;
  logic       we_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q, rdata_q;
  always_comb
    st_d = st_q == W_IDLE ? (go_i ? W_REQ : W_IDLE) :
           st_q == W_REQ  ? (wb_ack_i ? W_DONE : W_REQ) : W_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= W_IDLE;
      we_q    <= 1'b0;
      adr_q   <= 3'd0;
      dat_q   <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      st_q <= st_d;
      if (st_q == W_IDLE && go_i) {we_q, adr_q, dat_q} <= {we_i, adr_i, wdata_i};
      if (st_q == W_REQ && wb_ack_i) rdata_q <= wb_dat_i;
    end
  end
  assign wb_cyc_o = st_q == W_REQ;
  assign wb_stb_o = st_q == W_REQ;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign done_o   = st_q == W_DONE;
  assign rdata_o  = rdata_q;
endmodule

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: turns one cmd into the i2c_master_top register sequence (clk, rst, bus = cmd/rsp + Wishbone master)
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE   = 16'h0063,
  parameter int          POLL_LIMIT = 1024
) (
  input logic clk,
  input logic rst,
  i2c_reg_sequencer_if.master bus
);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam logic [PW-1:0] LIM_M1 = PW'(POLL_LIMIT - 1);
  state_t          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic [PW-1:0]   poll_q, poll_d;
  err_e            err_q, err_d, rsp_err_q;
  logic [7:0]      rdata_q, rdata_d, rsp_rdata_q;
  logic            init_done_q, init_done_d, busy_q;
  logic            rw_q;
  logic [6:0]      dev_q;
  logic [7:0]      reg_q, wd_q;
  logic            acc_req, acc_we, go, done;
  logic [2:0]      acc_adr;
  logic [7:0]      acc_wdata, rd;
  assign go = acc_req & ~busy_q;
  i2c_wb_access u_wb (
    .clk, .rst,
    .go_i(go), .we_i(acc_we), .adr_i(acc_adr), .wdata_i(acc_wdata),
    .done_o(done), .rdata_o(rd),
    .wb_cyc_o(bus.wb_cyc_o), .wb_stb_o(bus.wb_stb_o), .wb_we_o(bus.wb_we_o),
    .wb_adr_o(bus.wb_adr_o), .wb_dat_o(bus.wb_dat_o),
    .wb_dat_i(bus.wb_dat_i), .wb_ack_i(bus.wb_ack_i)
  );
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    poll_d      = poll_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    init_done_d = init_done_q;
    acc_req     = 1'b0;
    acc_we      = 1'b1;
    acc_adr     = CR_SR;
    acc_wdata   = 8'h00;
    case (state_q)
      INIT: begin
        acc_req   = 1'b1;
        acc_adr   = {1'b0, step_q};
        acc_wdata = step_q == 2'd0 ? PRESCALE[7:0] : step_q == 2'd1 ? PRESCALE[15:8] : CTR_EN;
        if (done) begin
          step_d      = step_q == 2'd2 ? 2'd0 : step_q + 2'd1;
          state_d     = step_q == 2'd2 ? IDLE : INIT;
          init_done_d = step_q == 2'd2;
        end
      end
      IDLE: if (bus.cmd_valid) begin
        state_d = TX_WR;
        step_d  = 2'd0;
        err_d   = ERR_OK;
        rdata_d = 8'h00;
      end
      TX_WR: begin
        acc_req   = 1'b1;
        acc_adr   = TXR_RXR;
        acc_wdata = step_q == 2'd0 ? {dev_q, 1'b0} : step_q == 2'd1 ? reg_q : rw_q ? {dev_q, 1'b1} : wd_q;
        if (done) state_d = CR_WR;
      end
      CR_WR: begin
        acc_req   = 1'b1;
        acc_wdata = step_q == 2'd0 ? CMD_STA_WR : step_q == 2'd1 ? CMD_WR :
                    step_q == 2'd3 ? CMD_RD_NACK_STO : rw_q ? CMD_STA_WR : CMD_STO_WR;
        if (done) begin
          state_d = POLL;
          poll_d  = '0;
        end
      end
      POLL: begin
        acc_req = 1'b1;
        acc_we  = 1'b0;
        if (done) begin
          if (rd[SR_TIP]) begin
            poll_d = poll_q + 1'b1;
            if (poll_q == LIM_M1) begin
              err_d   = ERR_AL_TMO;
              state_d = RESP;
            end
          end else if (rd[SR_AL]) begin
            err_d   = ERR_AL_TMO;
            state_d = ABORT_STO;
          end else if (rd[SR_RXACK] && step_q != 2'd3) begin
            // a NACKed write-data byte already carried STO, so no abort needed
            err_d   = step_q == 2'd0 ? ERR_ADDR_NACK : ERR_DATA_NACK;
            state_d = (step_q == 2'd2 && !rw_q) ? RESP : ABORT_STO;
          end else if (step_q == 2'd3) begin
            state_d = RX_RD;
          end else if (step_q == 2'd2) begin
            // read continues with the data byte step, which has no TXR write
            state_d = rw_q ? CR_WR : RESP;
            step_d  = 2'd3;
          end else begin
            state_d = TX_WR;
            step_d  = step_q + 2'd1;
          end
        end
      end
      RX_RD: begin
        acc_req = 1'b1;
        acc_we  = 1'b0;
        acc_adr = TXR_RXR;
        if (done) begin
          rdata_d = rd;
          state_d = RESP;
        end
      end
      ABORT_STO: begin
        acc_req   = 1'b1;
        acc_wdata = CMD_STO;
        if (done) begin
          state_d = ABORT_POLL;
          poll_d  = '0;
        end
      end
      ABORT_POLL: begin
        acc_req = 1'b1;
        acc_we  = 1'b0;
        if (done) begin
          poll_d  = poll_q + 1'b1;
          state_d = (!rd[SR_BUSY] || poll_q == LIM_M1) ? RESP : ABORT_POLL;
          err_d   = (rd[SR_BUSY] && poll_q == LIM_M1) ? ERR_AL_TMO : err_q;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      step_q      <= 2'd0;
      poll_q      <= '0;
      err_q       <= ERR_OK;
      rdata_q     <= 8'h00;
      rsp_err_q   <= ERR_OK;
      rsp_rdata_q <= 8'h00;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'h00;
      wd_q        <= 8'h00;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      poll_q      <= poll_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
      busy_q      <= go ? 1'b1 : done ? 1'b0 : busy_q;
      if (state_q == IDLE && bus.cmd_valid)
        {rw_q, dev_q, reg_q, wd_q} <= {bus.cmd_rw, bus.cmd_dev, bus.cmd_reg, bus.cmd_wdata};
      if (state_d == RESP) begin
        rsp_err_q   <= err_d;
        rsp_rdata_q <= rdata_d;
      end
    end
  end
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.init_done = init_done_q;
endmodule
